// File: rtl/rca_32bit_seq.sv
// Purpose : multi-cycle ripple-carry adder, one CHUNK-bit slice per clock, slice carry held in a register.
// Latency : start accepted at edge E; done strobe and results valid after edge E+N, N = WIDTH/CHUNK.
// Backpr. : start is ignored while busy=1 and is never queued; the done cycle has busy=0 and accepts a new start.
//
// Ports:
//   clk, rst          rising-edge clock; asynchronous active-high reset
//   start             request, sampled only while busy=0
//   a, b, carry_in    operands and carry into bit 0, latched with an accepted start
//   busy              high while slices are being added
//   done              one-cycle strobe, sum/carry/overflow were updated this cycle
//   sum               a+b+carry_in mod 2^WIDTH
//   carry             carry out of bit WIDTH-1
//   overflow          two's-complement overflow (carry into MSB xor carry out of MSB)
//
// WIDTH must be a multiple of CHUNK.
module rca_32bit_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int N     = WIDTH / CHUNK;
    // A one-slice configuration still needs a 1-bit index to keep the logic uniform.
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] work_sum;
    logic [WIDTH-1:0] work_sum_nxt;
    logic             run_c;

    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK:0]   sl_sum;
    logic             msb_cin;
    logic             last;
    logic             accept;

    // ------------------------------------------------------------------
    // Slice datapath
    // ------------------------------------------------------------------
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int s = 0; s < N; s++) begin
            if (idx == IDX_W'(s)) begin
                a_sl = a_reg[s*CHUNK +: CHUNK];
                b_sl = b_reg[s*CHUNK +: CHUNK];
            end
        end
    end

    assign sl_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, run_c};

    // Carry into the top bit of the current slice; only meaningful on the last
    // slice, where it is the carry into bit WIDTH-1.
    assign msb_cin = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ sl_sum[CHUNK-1];

    always_comb begin
        work_sum_nxt = work_sum;
        for (int s = 0; s < N; s++) begin
            if (idx == IDX_W'(s)) begin
                work_sum_nxt[s*CHUNK +: CHUNK] = sl_sum[CHUNK-1:0];
            end
        end
    end

    assign last   = (idx == LAST_IDX);
    assign accept = (state == IDLE) && start;
    assign busy   = (state == RUN);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Working registers and result outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            work_sum <= '0;
            run_c    <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_reg    <= a;
                b_reg    <= b;
                run_c    <= carry_in;
                idx      <= '0;
                work_sum <= '0;
            end else if (state == RUN) begin
                work_sum <= work_sum_nxt;
                run_c    <= sl_sum[CHUNK];
                idx      <= idx + 1'b1;
                if (last) begin
                    // Results are only published here, so outputs never show
                    // a partially accumulated sum. Index is parked at 0 so a
                    // non-power-of-two slice count cannot wrap into a stale slice.
                    idx      <= '0;
                    sum      <= work_sum_nxt;
                    carry    <= sl_sum[CHUNK];
                    overflow <= msb_cin ^ sl_sum[CHUNK];
                    done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rca_32bit_seq.sv
module tb_rca_32bit_seq;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    rca_32bit_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .carry_in (carry_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .carry    (carry),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Last published result, used to verify outputs hold while busy.
    logic [WIDTH-1:0] prev_sum = '0;
    logic             prev_c   = 1'b0;
    logic             prev_ov  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide addition; overflow from operand/result sign rule.
    function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             c);
        logic [WIDTH:0] full;
        logic           ov;
        full = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(c);
        ov   = (x[WIDTH-1] == y[WIDTH-1]) && (full[WIDTH-1] != x[WIDTH-1]);
        return {ov, full};
    endfunction

    task automatic check_result(input string tag, input logic [WIDTH-1:0] x,
                                input logic [WIDTH-1:0] y, input logic c);
        logic [WIDTH+1:0] r;
        r = ref_add(x, y, c);
        check({tag, ".sum"},   64'(sum),      64'(r[WIDTH-1:0]));
        check({tag, ".carry"}, 64'(carry),    64'(r[WIDTH]));
        check({tag, ".ovf"},   64'(overflow), 64'(r[WIDTH+1]));
        prev_sum = r[WIDTH-1:0];
        prev_c   = r[WIDTH];
        prev_ov  = r[WIDTH+1];
    endtask

    // One operation with full latency / hold checks; poke fires a start with
    // junk operands mid-RUN, which must be ignored.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input logic c, input bit poke);
        @(negedge clk);
        a = x; b = y; carry_in = c; start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= N; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start = 1'b0;
                a = $urandom; b = $urandom; carry_in = 1'($urandom);
            end
            if (k < N) begin
                check({tag, ".busy"},  64'(busy), 64'(1));
                check({tag, ".early"}, 64'(done), 64'(0));
                check({tag, ".hold"},  64'(sum),  64'(prev_sum));
                if (poke && k == 1) begin
                    start = 1'b1; a = $urandom; b = $urandom;
                end
                if (k == 2) start = 1'b0;
            end else begin
                check({tag, ".done"},  64'(done), 64'(1));
                check({tag, ".idle"},  64'(busy), 64'(0));
                check_result(tag, x, y, c);
            end
        end
        @(negedge clk);
        check({tag, ".strobe"}, 64'(done), 64'(0));
        check({tag, ".noq"},    64'(busy), 64'(0));
    endtask

    // start held high with operands changing every cycle: accepts every N+1.
    task automatic held_start(input int nops);
        logic [WIDTH-1:0] qa[$];
        logic [WIDTH-1:0] qb[$];
        logic             qc[$];
        @(negedge clk);
        a = $urandom; b = $urandom; carry_in = 1'($urandom); start = 1'b1;
        qa.push_back(a); qb.push_back(b); qc.push_back(carry_in);
        @(posedge clk);
        for (int t = 0; t < nops * (N + 1); t++) begin
            @(negedge clk);
            if (t % (N + 1) == N) begin
                check("held.done", 64'(done), 64'(1));
                check("held.busy", 64'(busy), 64'(0));
                check_result("held", qa.pop_front(), qb.pop_front(), qc.pop_front());
            end else begin
                check("held.nodone", 64'(done), 64'(0));
                check("held.busy1",  64'(busy), 64'(1));
                check("held.hold",   64'(sum),  64'(prev_sum));
            end
            a = $urandom; b = $urandom; carry_in = 1'($urandom);
            if (t % (N + 1) == N) begin
                if (t / (N + 1) < nops - 1) begin
                    qa.push_back(a); qb.push_back(b); qc.push_back(carry_in);
                end else begin
                    start = 1'b0;
                end
            end
        end
        @(negedge clk);
        check("held.end", 64'(busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst.busy", 64'(busy),     64'(0));
        check("rst.done", 64'(done),     64'(0));
        check("rst.sum",  64'(sum),      64'(0));
        check("rst.cout", 64'(carry),    64'(0));
        check("rst.ovf",  64'(overflow), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("cout",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("ovfpos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("ovfneg", 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        run_op("ripple", 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_op("sub1",   32'd10, ~32'd3,  1'b1, 1'b0);
        run_op("sub2",   32'd3,  ~32'd10, 1'b1, 1'b0);
        run_op("cinall", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        run_op("poke",   32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1);

        held_start(4);

        // Reset after two RUN edges: immediate clear, no done afterwards.
        @(negedge clk);
        a = 32'd5; b = 32'd7; carry_in = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid.busy", 64'(busy),     64'(0));
        check("mid.done", 64'(done),     64'(0));
        check("mid.sum",  64'(sum),      64'(0));
        check("mid.cout", 64'(carry),    64'(0));
        check("mid.ovf",  64'(overflow), 64'(0));
        prev_sum = '0; prev_c = 1'b0; prev_ov = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            check("mid.nodone", 64'(done), 64'(0));
        end
        run_op("after_rst", 32'd1, 32'd1, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            run_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
